// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the RV64I core.
// Owns the instruction register and drives datapath enables, muxes and memory handshakes.
module mc_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir_o,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   input  logic        zero_i,
   output logic [1:0]  alu_op,
   output logic        alu_src_a,
   output logic        alu_src_b,
   output logic [1:0]  wb_sel,
   output logic        rf_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        retire_o,
   output logic        trap_o,
   output logic [1:0]  trap_cause
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   logic [6:0] opc;
   logic [2:0] f3;
   logic is_lw, is_sw, is_addi, is_slti;
   logic is_auipc, is_beq, is_jal, is_jalr;
   logic legal;
   logic [1:0] sel_op;
   logic sel_a, sel_b;

   assign opc = ir_o[6:0];
   assign f3  = ir_o[14:12];

   assign is_lw    = (opc == 7'b0000011) && (f3 == 3'b010);
   assign is_addi  = (opc == 7'b0010011) && (f3 == 3'b000);
   assign is_slti  = (opc == 7'b0010011) && (f3 == 3'b010);
   assign is_beq   = (opc == 7'b1100011) && (f3 == 3'b000);
   assign is_sw    = (opc == 7'b0100011) && (f3 == 3'b010);
   assign is_jal   = (opc == 7'b1101111);
   assign is_auipc = (opc == 7'b0010111);
   assign is_jalr  = (opc == 7'b1100111) && (f3 == 3'b000);

   assign legal = is_lw | is_sw | is_addi | is_slti |
                  is_auipc | is_beq | is_jal | is_jalr;

   // ALU selects chosen in EX and held through MEM and WB
   assign sel_op = is_beq ? 2'd1 : (is_slti ? 2'd2 : 2'd0);
   assign sel_a  = is_auipc;
   assign sel_b  = ~(is_beq | is_jal);

   // State, instruction register, trap flags and request timeout counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         ir_o       <= '0;
         trap_o     <= 1'b0;
         trap_cause <= 2'd0;
         cnt        <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               state <= S_IF;
               cnt   <= '0;
            end
            S_IF: begin
               if (imem_ready) begin
                  ir_o  <= imem_rdata;
                  state <= S_ID;
               end else if (cnt == LIMIT) begin
                  trap_o     <= 1'b1;
                  trap_cause <= 2'd2;
                  state      <= S_TRAP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_ID: begin
               if (legal) begin
                  state <= S_EX;
               end else begin
                  trap_o     <= 1'b1;
                  trap_cause <= 2'd1;
                  state      <= S_TRAP;
               end
            end
            S_EX: begin
               cnt <= '0;
               if (is_lw | is_sw)
                  state <= S_MEM;
               else if (is_beq | is_jal | is_jalr)
                  state <= S_IF;
               else
                  state <= S_WB;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  cnt   <= '0;
                  state <= is_sw ? S_IF : S_WB;
               end else if (cnt == LIMIT) begin
                  trap_o     <= 1'b1;
                  trap_cause <= 2'd3;
                  state      <= S_TRAP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_WB: begin
               cnt   <= '0;
               state <= S_IF;
            end
            S_TRAP: state <= S_TRAP;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Datapath enables, muxes and requests decoded from state and ir_o
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      alu_op    = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      wb_sel    = 2'd0;
      rf_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      retire_o  = 1'b0;
      unique case (state)
         S_IF: imem_req = 1'b1;
         S_EX: begin
            alu_op    = sel_op;
            alu_src_a = sel_a;
            alu_src_b = sel_b;
            unique case (1'b1)
               is_beq: begin
                  pc_we    = 1'b1;
                  pc_src   = zero_i ? 2'd1 : 2'd0;
                  retire_o = 1'b1;
               end
               is_jal: begin
                  rf_we    = 1'b1;
                  wb_sel   = 2'd2;
                  pc_we    = 1'b1;
                  pc_src   = 2'd1;
                  retire_o = 1'b1;
               end
               is_jalr: begin
                  rf_we    = 1'b1;
                  wb_sel   = 2'd2;
                  pc_we    = 1'b1;
                  pc_src   = 2'd2;
                  retire_o = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            alu_op    = sel_op;
            alu_src_a = sel_a;
            alu_src_b = sel_b;
            dmem_req  = 1'b1;
            dmem_we   = is_sw;
            if (dmem_ready && is_sw) begin
               pc_we    = 1'b1;
               retire_o = 1'b1;
            end
         end
         S_WB: begin
            alu_op    = sel_op;
            alu_src_a = sel_a;
            alu_src_b = sel_b;
            rf_we     = 1'b1;
            wb_sel    = is_lw ? 2'd1 : 2'd0;
            pc_we     = 1'b1;
            retire_o  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for the multi-cycle control sequencer.
// Expected retire/trap records are queued per instruction and popped when the DUT reports.
module tb_mc_ctrl;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] ir_o;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ready = 1'b0;
   logic        zero_i = 1'b0;
   logic [1:0]  alu_op;
   logic        alu_src_a;
   logic        alu_src_b;
   logic [1:0]  wb_sel;
   logic        rf_we;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic        retire_o;
   logic        trap_o;
   logic [1:0]  trap_cause;

   int vectors = 0;
   int miscompares = 0;

   mc_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .ir_o(ir_o),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .zero_i(zero_i),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .wb_sel(wb_sel), .rf_we(rf_we), .pc_we(pc_we), .pc_src(pc_src),
      .retire_o(retire_o), .trap_o(trap_o), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        trap;
      logic [1:0]  cause;
      int          cyc;
      int          ireq;
      int          dreq;
      logic        we;
      logic        rfw;
      logic [1:0]  wbs;
      logic [1:0]  pcs;
      logic [1:0]  aop;
      logic        sa;
      logic        sb;
      logic [31:0] ir;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ins, input int iw,
                                  input int dw, input logic z);
      exp_t e;
      logic [6:0] op;
      logic [2:0] f3;
      bit lw, sw, ad, sl, au, bq, jl, jr, mem, ok;
      op = ins[6:0];
      f3 = ins[14:12];
      lw = (op == 7'h03) && (f3 == 3'd2);
      sw = (op == 7'h23) && (f3 == 3'd2);
      ad = (op == 7'h13) && (f3 == 3'd0);
      sl = (op == 7'h13) && (f3 == 3'd2);
      au = (op == 7'h17);
      jl = (op == 7'h6F);
      bq = (op == 7'h63) && (f3 == 3'd0);
      jr = (op == 7'h67) && (f3 == 3'd0);
      ok = lw | sw | ad | sl | au | jl | bq | jr;
      mem = lw | sw;
      e = '{default: 0};
      e.ir = ins;
      e.we = sw;
      e.ireq = (iw >= TO) ? TO : iw + 1;
      if (iw >= TO) begin
         e.trap = 1'b1; e.cause = 2'd2; e.cyc = TO + 1;
      end else if (!ok) begin
         e.trap = 1'b1; e.cause = 2'd1; e.cyc = iw + 3;
      end else if (mem && dw >= TO) begin
         e.trap = 1'b1; e.cause = 2'd3; e.cyc = iw + TO + 4;
         e.dreq = TO;
      end else begin
         e.dreq = mem ? dw + 1 : 0;
         e.cyc = iw + ((bq | jl | jr) ? 3 : (lw ? 5 : 4)) + (mem ? dw : 0);
         e.rfw = !(bq | sw);
         e.wbs = lw ? 2'd1 : ((jl | jr) ? 2'd2 : 2'd0);
         e.pcs = bq ? {1'b0, z} : (jl ? 2'd1 : (jr ? 2'd2 : 2'd0));
         e.aop = bq ? 2'd1 : (sl ? 2'd2 : 2'd0);
         e.sa = au;
         e.sb = !(bq | jl);
      end
      return e;
   endfunction

   // Drive one instruction with the given memory waits; ready pulses while idle are noise.
   task automatic run(input logic [31:0] ins, input int iw, input int dw,
                      input logic z);
      exp_t e, g;
      int n, ic, dc, pcw, rfw, dbad;
      bit seen, done;
      e = model(ins, iw, dw, z);
      sbq.push_back(e);
      n = 0; ic = 0; dc = 0; pcw = 0; rfw = 0; dbad = 0;
      seen = 0; done = 0;
      for (int k = 0; k < 80 && !done; k++) begin
         @(negedge clk);
         imem_ready = imem_req ? (ic == iw) : 1'b1;
         imem_rdata = imem_req ? ins : 32'hFFFF_FFFF;
         dmem_ready = dmem_req ? (dc == dw) : 1'b1;
         zero_i = z;
         #1;
         if (imem_req) begin
            seen = 1;
            ic++;
         end
         if (seen) n++;
         if (dmem_req) begin
            dc++;
            if (dmem_we !== e.we) dbad++;
         end
         if (pc_we) pcw++;
         if (rf_we) rfw++;
         if (retire_o || trap_o) begin
            done = 1;
            g = sbq.pop_front();
            chk("cycles", n, g.cyc);
            chk("trap", trap_o, g.trap);
            chk("imem_req_cycles", ic, g.ireq);
            chk("dmem_req_cycles", dc, g.dreq);
            chk("dmem_we", dbad, 0);
            if (g.trap) begin
               chk("trap_cause", trap_cause, g.cause);
               chk("retire_on_trap", retire_o, 0);
            end else begin
               chk("ir", ir_o, g.ir);
               chk("pc_we", pc_we, 1);
               chk("rf_we", rf_we, g.rfw);
               chk("wb_sel", wb_sel, g.wbs);
               chk("pc_src", pc_src, g.pcs);
               chk("alu_op", alu_op, g.aop);
               chk("alu_src", {alu_src_a, alu_src_b}, {g.sa, g.sb});
            end
            chk("pc_we_count", pcw, g.trap ? 0 : 1);
            chk("rf_we_count", rfw, g.rfw ? 1 : 0);
         end
      end
      if (!done) begin
         chk("no_response", 0, 1);
         void'(sbq.pop_front());
      end
   endtask

   // After a trap the block must sit still with the flag held.
   task automatic trap_hold(input logic [1:0] cause);
      int bad;
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         imem_ready = 1'b1;
         dmem_ready = 1'b1;
         #1;
         if (imem_req || dmem_req || rf_we || pc_we || retire_o) bad++;
         if (!trap_o || trap_cause != cause) bad++;
      end
      chk("trap_hold", bad, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_outs", {imem_req, dmem_req, dmem_we, rf_we, pc_we, retire_o,
                       trap_o, trap_cause, alu_op, alu_src_a, alu_src_b,
                       wb_sel, pc_src}, 0);
      chk("rst_ir", ir_o, 0);
      rst = 1'b0;
   endtask

   logic [31:0] legal_tab [8] = '{
      32'h00500093, 32'h0070A193, 32'h00001297, 32'h0080A103,
      32'h0020A223, 32'h00208463, 32'h010000EF, 32'h000080E7
   };

   logic [31:0] illegal_tab [6] = '{
      32'hFFFFFFFF, 32'h00009093, 32'h00008103,
      32'h00001063, 32'h00000033, 32'h000090E7
   };

   initial begin
      do_reset();
      run(32'h00500093, 0, 0, 1'b0);
      run(32'h0080A103, 0, 3, 1'b0);
      run(32'h00208463, 0, 0, 1'b1);
      run(32'h00208463, 0, 0, 1'b0);
      run(32'h000080E7, 0, 0, 1'b0);
      run(32'h0070A193, 1, 0, 1'b0);
      run(32'h00001297, 0, 0, 1'b0);
      run(32'h0020A223, 2, 1, 1'b0);
      run(32'h010000EF, 0, 0, 1'b0);
      run(32'h00500093, TO - 1, 0, 1'b0);
      run(32'h0080A103, 0, TO - 1, 1'b0);
      run(32'h0020A223, 0, TO - 1, 1'b0);

      run(32'h00500093, 99, 0, 1'b0);
      trap_hold(2'd2);
      do_reset();
      run(32'h0080A103, 0, 99, 1'b0);
      trap_hold(2'd3);
      do_reset();

      foreach (illegal_tab[i]) begin
         run(illegal_tab[i], i % 2, 0, 1'b0);
         trap_hold(2'd1);
         do_reset();
      end

      // Reset while a fetch is still pending
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      imem_ready = 1'b0;
      #1;
      chk("pending_req", imem_req, 1);
      rst = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      #1;
      chk("mid_rst_outs", {imem_req, rf_we, pc_we, retire_o}, 0);
      chk("mid_rst_ir", ir_o, 0);
      rst = 1'b0;

      for (int r = 0; r < 10; r++)
         run(legal_tab[$urandom_range(7)], $urandom_range(3),
             $urandom_range(3), 1'(($urandom_range(1))));

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the RV64I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It owns the instruction register that feeds the immediate generator. It drives all datapath enables and muxes, and it holds valid/ready handshakes with instruction and data memory. Its decode-stage wait covers the one-cycle registered latency of the immediate generator.

## Interface
Parameters:
- TIMEOUT, default 15: maximum number of cycles a memory request may stay unanswered before a trap.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid; sampled only while imem_req=1.
- imem_rdata  in  32  fetched instruction.
- ir_o  out  32  instruction register; feeds the immediate generator and the register-file address fields.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid only while dmem_req=1.
- dmem_ready  in  1  data access complete.
- zero_i  in  1  ALU zero flag, used for beq.
- alu_op  out  2  0 = add, 1 = sub, 2 = set-less-than signed.
- alu_src_a  out  1  0 = rs1, 1 = pc.
- alu_src_b  out  1  0 = rs2, 1 = imm.
- wb_sel  out  2  register write data: 0 = ALU, 1 = load data, 2 = pc+4.
- rf_we  out  1  register-file write enable.
- pc_we  out  1  pc write enable.
- pc_src  out  2  next pc: 0 = pc+4, 1 = pc+imm, 2 = (ALU result) & ~1.
- retire_o  out  1  one-cycle pulse in the final cycle of each instruction.
- trap_o  out  1  sticky error flag.
- trap_cause  out  2  1 = illegal instruction, 2 = imem timeout, 3 = dmem timeout.

## Operation
- States: IDLE, IF, ID, EX, MEM, WB, TRAP.
- Outputs are decoded from state and ir_o. Every enable and request is 0 in any state or case not listed below.
- Reset: state = IDLE. Also ir_o = 0, trap_o = 0, trap_cause = 0, timeout counter = 0, and all outputs 0. IDLE always moves to IF on the next cycle.
- IF:
  - imem_req = 1.
  - On imem_ready: latch imem_rdata into ir_o, go to ID.
- ID: one cycle with no enables, while the immediate generator registers imm. Legality check:
  - opcode 0000011 requires funct3 = 010 (lw).
  - opcode 0010011 requires funct3 = 000 (addi) or 010 (slti).
  - opcode 1100011 requires funct3 = 000 (beq).
  - opcode 0100011 requires funct3 = 010 (sw).
  - opcodes 1101111 (jal) and 0010111 (auipc) are legal with any funct3.
  - opcode 1100111 requires funct3 = 000 (jalr).
  - Any other encoding sets trap_o = 1, trap_cause = 1 and goes to TRAP.
  - Otherwise go to EX.
- EX, per instruction:
  - addi: alu_op = 0, src_b = 1, then WB.
  - slti: alu_op = 2, src_b = 1, then WB.
  - auipc: alu_op = 0, src_a = 1, src_b = 1, then WB.
  - lw / sw: alu_op = 0, src_b = 1, then MEM.
  - beq: alu_op = 1, src_b = 0, pc_we = 1, pc_src = zero_i ? 1 : 0, retire, then IF.
  - jal: rf_we = 1, wb_sel = 2, pc_we = 1, pc_src = 1, retire, then IF.
  - jalr: alu_op = 0, src_b = 1, rf_we = 1, wb_sel = 2, pc_we = 1, pc_src = 2, retire, then IF. When rd = rs1, the ALU still reads the old rs1.
- MEM:
  - dmem_req = 1, dmem_we = (sw). ALU selects are held from EX.
  - On dmem_ready, sw: pc_we = 1, pc_src = 0, retire, then IF.
  - On dmem_ready, lw: go to WB.
- WB: rf_we = 1, wb_sel = 1 for lw and 0 otherwise, pc_we = 1, pc_src = 0, retire, then IF. ALU selects are held from EX.
- TRAP: absorbing state with all enables 0. Only rst leaves it.
- Timeout counter:
  - Cleared on entry to IF or MEM.
  - Increments each cycle the request is pending and ready is low.
  - When the counter reaches TIMEOUT with ready still low: set trap_o, set trap_cause = 2 (IF) or 3 (MEM), go to TRAP.
  - If ready arrives in the same cycle as the limit, ready wins.

## Timing
- A request is held high until ready is sampled 1. It drops in the cycle after acceptance.
- A ready pulse while the request is low is ignored.
- Cycles per instruction with zero-wait memory (ready in the first request cycle):
  - beq, jal, jalr: 3.
  - addi, slti, auipc, sw: 4.
  - lw: 5.
- Each memory wait cycle adds 1.
- retire_o fires exactly once per instruction, in the same cycle as that instruction's pc_we.
- rst asserted mid-instruction (including during a pending request) forces IDLE at the next edge. No write enable asserts in the cycle after rst is sampled.
- ir_o changes only on IF acceptance.

## Test plan
- Reset then addi x1,x0,5 (0x00500093), zero-wait memory:
  - Required sequence: IDLE, IF, ID, EX, WB.
  - In WB: rf_we = 1, wb_sel = 0, pc_src = 0.
  - retire_o asserts 4 cycles after the first imem_req.
- lw x2,8(x1) with dmem_ready delayed 3 cycles:
  - dmem_req high for 4 cycles with dmem_we = 0.
  - Then WB with wb_sel = 1.
  - Total 8 cycles.
- beq with zero_i = 1 versus zero_i = 0:
  - In EX, pc_src = 1 versus 0.
  - rf_we = 0 throughout; 3 cycles each.
- jalr x1,0(x1):
  - EX asserts rf_we = 1, wb_sel = 2, pc_src = 2 and pc_we in one cycle.
  - Next state is IF.
- Illegal instruction 0xFFFFFFFF:
  - trap_o = 1 and trap_cause = 1 after ID.
  - imem_req stays 0 forever.
  - rst returns the block to IDLE with trap_o = 0.
- imem_ready held low with TIMEOUT = 15:
  - trap_cause = 2 after 15 pending cycles.
  - Separately, with ready asserted on the 15th cycle, no trap occurs.
